// File: rtl/usb4_logical_layer.sv
`default_nettype none
// ============================================================================
// Module   : usb4_logical_layer
// Purpose  : Simplified USB4 logical layer. A config-space CTRL bit enables the
//            link. The link first exchanges 0x5A sync bytes on a UART-style
//            sideband. It then trains both lanes on the 0xA5 pattern. In CL0 it
//            moves 16-bit transport words across two 8-bit lanes and counts
//            the words sent and received.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : local_clk, rst                 clock / async active-high reset
//            lane_disable                   force link to DISABLED
//            c_read, c_write, c_address,
//            c_data_in, c_data_out          config-space access
//            transport_layer_data_in/out,
//            transport_data_flag            transport words (tx / rx / rx valid)
//            lane_0/1_rx_i, enable_deser    lane receive bytes + valid
//            lane_0/1_tx_o                  lane transmit bytes
//            sbrx, sbtx                     sideband serial in / out
//            enable_scr, cl0_s              scrambler enable, link-up status
// ============================================================================
module usb4_logical_layer #(
  parameter int SB_DIV    = 8,
  parameter int TRAIN_CNT = 4
) (
  input  logic        local_clk,
  input  logic        rst,
  input  logic        lane_disable,
  input  logic        c_read,
  input  logic        c_write,
  input  logic [7:0]  c_address,
  input  logic [31:0] c_data_in,
  output logic [31:0] c_data_out,
  input  logic [15:0] transport_layer_data_in,
  output logic [15:0] transport_layer_data_out,
  output logic        transport_data_flag,
  input  logic [7:0]  lane_0_rx_i,
  input  logic [7:0]  lane_1_rx_i,
  input  logic        enable_deser,
  output logic [7:0]  lane_0_tx_o,
  output logic [7:0]  lane_1_tx_o,
  input  logic        sbrx,
  output logic        sbtx,
  output logic        enable_scr,
  output logic        cl0_s
);

  typedef enum logic [1:0] {
    DISABLED   = 2'd0,
    SB_SYNC    = 2'd1,
    LANE_TRAIN = 2'd2,
    CL0        = 2'd3
  } state_t;

  localparam int              DIVW         = $clog2(SB_DIV + 1);
  localparam int              TW           = $clog2(TRAIN_CNT + 1);
  localparam logic [DIVW-1:0] DIV_LAST     = DIVW'(SB_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF     = DIVW'(SB_DIV / 2);
  localparam logic [DIVW-1:0] DIV_FULL     = DIVW'(SB_DIV);
  localparam logic [TW-1:0]   TRAIN_TGT    = TW'(TRAIN_CNT);
  localparam logic [7:0]      SYNC_BYTE    = 8'h5A;
  localparam logic [7:0]      TRAIN_BYTE   = 8'hA5;
  // Sideband TX bit slots: 0 start, 1..8 data, 9 stop, 10 inter-frame idle.
  localparam logic [3:0]      TX_STOP      = 4'd9;
  localparam logic [3:0]      TX_IDLE      = 4'd10;
  localparam logic [3:0]      RX_STOP      = 4'd9;

  state_t            state, state_nxt;
  logic              link_en, link_en_nxt;
  logic              sb_done;
  logic [3:0]        tx_bit, tx_bit_nxt;
  logic [DIVW-1:0]   tx_div, tx_div_nxt;
  logic              rx_busy;
  logic [3:0]        rx_bit;
  logic [DIVW-1:0]   rx_cnt;
  logic [7:0]        rx_shift;
  logic              sb_s0, sb_s1;
  logic [TW-1:0]     train_cnt, train_nxt;
  logic [31:0]       txcnt, rxcnt;
  logic [31:0]       rd_data;
  logic              force_dis, tx_frame_end, lanes_match, rx_take;

  // Value driven on sbtx for a given TX bit slot.
  function automatic logic frame_bit(input logic [3:0] b);
    logic [7:0] sh;
    sh = SYNC_BYTE >> (b - 4'd1);
    if (b == 4'd0)      return 1'b0;
    else if (b <= 4'd8) return sh[0];
    else                return 1'b1;
  endfunction

  assign force_dis    = lane_disable | ~link_en;
  assign tx_frame_end = (state == SB_SYNC) && (tx_bit == TX_STOP) && (tx_div == DIV_LAST);
  assign lanes_match  = (lane_0_rx_i == TRAIN_BYTE) && (lane_1_rx_i == TRAIN_BYTE);
  // First sample lands mid start bit, later ones one full bit-time apart.
  assign rx_take      = rx_busy && (rx_cnt == ((rx_bit == 4'd0) ? DIV_HALF : DIV_FULL));
  // A same-edge write is visible to a same-edge read of CTRL.
  assign link_en_nxt  = (c_write && (c_address == 8'h00)) ? c_data_in[0] : link_en;

  always_comb begin
    rd_data = 32'h0;
    case (c_address)
      8'h00:   rd_data = {31'h0, link_en_nxt};
      8'h04:   rd_data = {28'h0, state, sb_done, cl0_s};
      8'h08:   rd_data = txcnt;
      8'h0C:   rd_data = rxcnt;
      default: rd_data = 32'h0;
    endcase
  end

  always_comb begin
    train_nxt = train_cnt;
    if (enable_deser)
      train_nxt = lanes_match ? train_cnt + 1'b1 : '0;
  end

  always_comb begin
    tx_bit_nxt = '0;
    tx_div_nxt = '0;
    if (state == SB_SYNC) begin
      if (tx_div == DIV_LAST) begin
        tx_bit_nxt = (tx_bit == TX_IDLE) ? 4'd0 : tx_bit + 4'd1;
      end else begin
        tx_div_nxt = tx_div + 1'b1;
        tx_bit_nxt = tx_bit;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (force_dis) begin
      state_nxt = DISABLED;
    end else begin
      case (state)
        DISABLED:   state_nxt = SB_SYNC;
        SB_SYNC:    if (sb_done && tx_frame_end) state_nxt = LANE_TRAIN;
        LANE_TRAIN: if (train_nxt == TRAIN_TGT) state_nxt = CL0;
        CL0:        state_nxt = CL0;
        default:    state_nxt = DISABLED;
      endcase
    end
  end

  // All outputs are decoded from the next state so they line up with it.
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      state                    <= DISABLED;
      link_en                  <= 1'b0;
      c_data_out               <= 32'h0;
      sb_done                  <= 1'b0;
      tx_bit                   <= '0;
      tx_div                   <= '0;
      sbtx                     <= 1'b1;
      rx_busy                  <= 1'b0;
      rx_bit                   <= '0;
      rx_cnt                   <= '0;
      rx_shift                 <= '0;
      sb_s0                    <= 1'b1;
      sb_s1                    <= 1'b1;
      train_cnt                <= '0;
      txcnt                    <= 32'h0;
      rxcnt                    <= 32'h0;
      lane_0_tx_o              <= 8'h00;
      lane_1_tx_o              <= 8'h00;
      transport_layer_data_out <= 16'h0;
      transport_data_flag      <= 1'b0;
      enable_scr               <= 1'b0;
      cl0_s                    <= 1'b0;
    end else begin
      state      <= state_nxt;
      link_en    <= link_en_nxt;
      if (c_read) c_data_out <= rd_data;
      sb_s0      <= sbrx;
      sb_s1      <= sb_s0;
      cl0_s      <= (state_nxt == CL0);
      enable_scr <= (state_nxt == LANE_TRAIN) || (state_nxt == CL0);

      // Sideband transmitter: free-running 0x5A frames while in SB_SYNC.
      if (state_nxt == SB_SYNC) begin
        tx_bit <= tx_bit_nxt;
        tx_div <= tx_div_nxt;
        sbtx   <= frame_bit(tx_bit_nxt);
      end else begin
        tx_bit <= '0;
        tx_div <= '0;
        sbtx   <= 1'b1;
      end

      // Sideband receiver on the synchronised sbrx (sb_s0 newest sample).
      if ((state == SB_SYNC) && (state_nxt == SB_SYNC)) begin
        if (!rx_busy) begin
          if (sb_s1 && !sb_s0) begin
            rx_busy <= 1'b1;
            rx_bit  <= '0;
            rx_cnt  <= DIVW'(1);
          end
        end else if (rx_take) begin
          rx_cnt <= DIVW'(1);
          rx_bit <= rx_bit + 4'd1;
          if (rx_bit == RX_STOP) begin
            rx_busy <= 1'b0;
            if (sb_s0 && (rx_shift == SYNC_BYTE)) sb_done <= 1'b1;
          end else if (rx_bit != 4'd0) begin
            rx_shift <= {sb_s0, rx_shift[7:1]};
          end
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else begin
        rx_busy <= 1'b0;
        rx_bit  <= '0;
        rx_cnt  <= '0;
        sb_done <= 1'b0;
      end

      if ((state == LANE_TRAIN) && (state_nxt == LANE_TRAIN)) train_cnt <= train_nxt;
      else                                                      train_cnt <= '0;

      case (state_nxt)
        LANE_TRAIN: begin
          lane_0_tx_o <= TRAIN_BYTE;
          lane_1_tx_o <= TRAIN_BYTE;
        end
        CL0: begin
          lane_0_tx_o <= transport_layer_data_in[7:0];
          lane_1_tx_o <= transport_layer_data_in[15:8];
        end
        default: begin
          lane_0_tx_o <= 8'h00;
          lane_1_tx_o <= 8'h00;
        end
      endcase

      if (state_nxt == CL0) begin
        txcnt <= txcnt + 32'd1;
        if ((state == CL0) && enable_deser) begin
          transport_layer_data_out <= {lane_1_rx_i, lane_0_rx_i};
          transport_data_flag      <= 1'b1;
          rxcnt                    <= rxcnt + 32'd1;
        end else begin
          transport_data_flag <= 1'b0;
        end
      end else begin
        txcnt               <= 32'h0;
        rxcnt               <= 32'h0;
        transport_data_flag <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb4_logical_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb4_logical_layer
// Purpose  : Self-checking bench for usb4_logical_layer. It runs the
//            config-space vector table, sideband sync with bad frames and
//            loopback, the lane-training sequence, CL0 traffic against a
//            queue-free reference model, disable and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb4_logical_layer;
  localparam int SB_DIV    = 8;
  localparam int TRAIN_CNT = 4;
  localparam int FRAME_CYC = 11 * SB_DIV;

  logic        local_clk = 1'b0;
  logic        rst = 1'b1;
  logic        lane_disable, c_read, c_write;
  logic [7:0]  c_address;
  logic [31:0] c_data_in, c_data_out;
  logic [15:0] transport_layer_data_in, transport_layer_data_out;
  logic        transport_data_flag;
  logic [7:0]  lane_0_rx_i, lane_1_rx_i, lane_0_tx_o, lane_1_tx_o;
  logic        enable_deser, sbrx, sbtx, enable_scr, cl0_s;
  logic        sbrx_drv, loop_en;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  assign sbrx = loop_en ? sbtx : sbrx_drv;

  usb4_logical_layer #(.SB_DIV(SB_DIV), .TRAIN_CNT(TRAIN_CNT)) dut (
    .local_clk(local_clk), .rst(rst), .lane_disable(lane_disable),
    .c_read(c_read), .c_write(c_write), .c_address(c_address),
    .c_data_in(c_data_in), .c_data_out(c_data_out),
    .transport_layer_data_in(transport_layer_data_in),
    .transport_layer_data_out(transport_layer_data_out),
    .transport_data_flag(transport_data_flag),
    .lane_0_rx_i(lane_0_rx_i), .lane_1_rx_i(lane_1_rx_i),
    .enable_deser(enable_deser),
    .lane_0_tx_o(lane_0_tx_o), .lane_1_tx_o(lane_1_tx_o),
    .sbrx(sbrx), .sbtx(sbtx), .enable_scr(enable_scr), .cl0_s(cl0_s)
  );

  always #5 local_clk = ~local_clk;
  always @(posedge local_clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } cfg_vec_t;

  typedef struct {
    logic       deser;
    logic [7:0] l0;
    logic [7:0] l1;
    logic       exp_cl0;
  } trn_vec_t;

  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd_raw(input logic [7:0] a, output logic [31:0] v);
    c_address = a;
    c_read    = 1'b1;
    tick();
    c_read    = 1'b0;
    v         = c_data_out;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    logic [31:0] v;
    rd_raw(a, v);
    check(name, v, exp);
  endtask

  task automatic send_sb(input logic [7:0] b, input logic stop);
    sbrx_drv = 1'b0;
    repeat (SB_DIV) tick();
    for (int k = 0; k < 8; k++) begin
      sbrx_drv = b[k];
      repeat (SB_DIV) tick();
    end
    sbrx_drv = stop;
    repeat (SB_DIV) tick();
    sbrx_drv = 1'b1;
    repeat (2 * SB_DIV) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_vec_t    cfg[12];
    trn_vec_t    trn[8];
    logic [9:0]  frame, exp_frame;
    logic [31:0] v0, v1;
    logic [15:0] exp_out;
    int          c0, c1, rxw, t0;
    bit          found;

    lane_disable = 1'b1; c_read = 1'b0; c_write = 1'b0; c_address = 8'h00;
    c_data_in = 32'h0; transport_layer_data_in = 16'h0;
    lane_0_rx_i = 8'h00; lane_1_rx_i = 8'h00; enable_deser = 1'b0;
    sbrx_drv = 1'b1; loop_en = 1'b0;

    // Reset values while rst is held
    tick(); tick();
    check("rst sbtx",       32'(sbtx), 32'd1);
    check("rst c_data_out", c_data_out, 32'h0);
    check("rst lane0",      32'(lane_0_tx_o), 32'h0);
    check("rst lane1",      32'(lane_1_tx_o), 32'h0);
    check("rst cl0_s",      32'(cl0_s), 32'd0);
    check("rst enable_scr", 32'(enable_scr), 32'd0);
    check("rst flag",       32'(transport_data_flag), 32'd0);
    check("rst tl_out",     32'(transport_layer_data_out), 32'h0);
    #4 rst = 1'b0;
    tick();

    // Config space, lane_disable held so the link stays DISABLED
    cfg[0]  = '{1'b0, 1'b1, 8'h00, 32'h0, 32'h0};
    cfg[1]  = '{1'b0, 1'b1, 8'h04, 32'h0, 32'h0};
    cfg[2]  = '{1'b1, 1'b1, 8'h00, 32'h1, 32'h1};
    cfg[3]  = '{1'b0, 1'b0, 8'h00, 32'h0, 32'h1};
    cfg[4]  = '{1'b1, 1'b0, 8'h10, 32'h0, 32'h1};
    cfg[5]  = '{1'b0, 1'b1, 8'h10, 32'h0, 32'h0};
    cfg[6]  = '{1'b0, 1'b1, 8'h00, 32'h0, 32'h1};
    cfg[7]  = '{1'b0, 1'b1, 8'h04, 32'h0, 32'h0};
    cfg[8]  = '{1'b0, 1'b1, 8'h08, 32'h0, 32'h0};
    cfg[9]  = '{1'b0, 1'b1, 8'h0C, 32'h0, 32'h0};
    cfg[10] = '{1'b1, 1'b1, 8'h00, 32'h0, 32'h0};
    cfg[11] = '{1'b1, 1'b1, 8'h00, 32'h1, 32'h1};
    for (int i = 0; i < 12; i++) begin
      c_write = cfg[i].wr; c_read = cfg[i].rd;
      c_address = cfg[i].addr; c_data_in = cfg[i].wdata;
      tick();
      c_write = 1'b0; c_read = 1'b0;
      check($sformatf("cfg vec %0d", i), c_data_out, cfg[i].exp);
    end

    // Sideband: capture our own first 0x5A frame on sbtx
    lane_disable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (sbtx == 1'b0) found = 1'b1;
    end
    check("sb start seen", 32'(found), 32'd1);
    t0 = cyc;
    repeat (SB_DIV / 2) tick();
    frame[0] = sbtx;
    for (int k = 1; k < 10; k++) begin
      repeat (SB_DIV) tick();
      frame[k] = sbtx;
    end
    exp_frame = {1'b1, 8'h5A, 1'b0};
    check("sb tx frame", 32'(frame), 32'(exp_frame));

    // Wrong byte and bad stop bit must both be ignored
    send_sb(8'h33, 1'b1);
    send_sb(8'h5A, 1'b0);
    rd(8'h04, 32'h4, "status after bad frames");

    // Close the loop at a frame boundary (mid stop bit)
    for (int i = 0; i < FRAME_CYC + 4 && ((cyc - t0) % FRAME_CYC) != 76; i++) tick();
    loop_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (enable_scr) found = 1'b1;
    end
    check("reach lane_train", 32'(found), 32'd1);
    check("lt sbtx idle", 32'(sbtx), 32'd1);
    check("lt cl0_s", 32'(cl0_s), 32'd0);
    rd(8'h04, 32'h8, "status lane_train");
    loop_en = 1'b0;

    // Lane training: mismatch restarts, deser=0 holds
    trn[0] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
    trn[1] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
    trn[2] = '{1'b1, 8'h00, 8'hA5, 1'b0};
    trn[3] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
    trn[4] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
    trn[5] = '{1'b0, 8'hA5, 8'hA5, 1'b0};
    trn[6] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
    trn[7] = '{1'b1, 8'hA5, 8'hA5, 1'b1};
    for (int i = 0; i < 8; i++) begin
      enable_deser = trn[i].deser;
      lane_0_rx_i = trn[i].l0; lane_1_rx_i = trn[i].l1;
      tick();
      check($sformatf("train cl0_s %0d", i), 32'(cl0_s), 32'(trn[i].exp_cl0));
      check($sformatf("train lane0 %0d", i), 32'(lane_0_tx_o),
            trn[i].exp_cl0 ? 32'(transport_layer_data_in[7:0]) : 32'hA5);
    end
    enable_deser = 1'b0;
    check("cl0 enable_scr", 32'(enable_scr), 32'd1);
    rd(8'h04, 32'hD, "status cl0");
    rd(8'h0C, 32'h0, "rxcnt start");
    rd_raw(8'h08, v0);
    c0 = cyc;

    // CL0 traffic: directed 0x1234.. words, then random, against a model
    exp_out = 16'h0;
    rxw = 0;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      logic        de;
      logic [7:0]  a, b;
      if (i < 7) begin
        d = 16'(16'h1234 + i); de = (i == 0); a = 8'hEF; b = 8'hBE;
      end else begin
        d = 16'($urandom); de = 1'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom);
      end
      transport_layer_data_in = d;
      enable_deser = de;
      lane_0_rx_i = a; lane_1_rx_i = b;
      tick();
      if (de) begin
        exp_out = {b, a};
        rxw++;
      end
      check($sformatf("cl0 lane0 %0d", i), 32'(lane_0_tx_o), 32'(d[7:0]));
      check($sformatf("cl0 lane1 %0d", i), 32'(lane_1_tx_o), 32'(d[15:8]));
      check($sformatf("cl0 flag %0d", i), 32'(transport_data_flag), 32'(de));
      check($sformatf("cl0 rxdata %0d", i), 32'(transport_layer_data_out), 32'(exp_out));
    end
    enable_deser = 1'b0;
    rd(8'h0C, 32'(rxw), "rxcnt");
    rd_raw(8'h08, v1);
    c1 = cyc;
    check("txcnt delta", v1 - v0, 32'(c1 - c0));

    // lane_disable in CL0
    transport_layer_data_in = 16'hFFFF;
    enable_deser = 1'b1;
    lane_0_rx_i = 8'h11; lane_1_rx_i = 8'h22;
    lane_disable = 1'b1;
    tick();
    enable_deser = 1'b0;
    check("dis cl0_s", 32'(cl0_s), 32'd0);
    check("dis enable_scr", 32'(enable_scr), 32'd0);
    check("dis lane0", 32'(lane_0_tx_o), 32'h0);
    check("dis lane1", 32'(lane_1_tx_o), 32'h0);
    check("dis flag", 32'(transport_data_flag), 32'd0);
    rd(8'h04, 32'h0, "dis status");
    rd(8'h08, 32'h0, "dis txcnt");
    rd(8'h0C, 32'h0, "dis rxcnt");
    rd(8'h00, 32'h1, "ctrl kept");

    // Asynchronous reset in the middle of a sideband frame
    lane_disable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (sbtx == 1'b0) found = 1'b1;
    end
    check("sb restart seen", 32'(found), 32'd1);
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    check("arst sbtx", 32'(sbtx), 32'd1);
    check("arst c_data_out", c_data_out, 32'h0);
    check("arst tl_out", 32'(transport_layer_data_out), 32'h0);
    check("arst lane0", 32'(lane_0_tx_o), 32'h0);
    check("arst enable_scr", 32'(enable_scr), 32'd0);
    check("arst cl0_s", 32'(cl0_s), 32'd0);
    tick();
    #3 rst = 1'b0;
    tick();
    rd(8'h00, 32'h0, "arst ctrl");
    rd(8'h04, 32'h0, "arst status");
    check("arst sbtx idle", 32'(sbtx), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb4_logical_layer.md
USB4_LOGICAL_LAYER -- requirements
Module: usb4_logical_layer

Interface
REQ-001 SHALL have a single clock and asynchronous active-high reset: one clock (local_clk), reset rst asynchronous active-high.
REQ-002 Parameter SB_DIV, default 8: local_clk cycles per sideband bit.
REQ-003 Parameter TRAIN_CNT, default 4: consecutive matching training words required on both lanes.
REQ-004 local_clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  async active-high reset.
REQ-006 lane_disable  in  1  forces link to DISABLED.
REQ-007 c_read / c_write  in  1 each  config-space access strobes.
REQ-008 c_address  in  8  config register byte address.
REQ-009 c_data_in  in  32  write data; c_data_out  out  32  read data.
REQ-010 transport_layer_data_in  in  16  transmit word; transport_layer_data_out  out  16  receive word.
REQ-011 transport_data_flag  out  1  receive word valid.
REQ-012 lane_0_rx_i / lane_1_rx_i  in  8 each  parallel lane receive bytes.
REQ-013 enable_deser  in  1  lane receive bytes valid this cycle.
REQ-014 lane_0_tx_o / lane_1_tx_o  out  8 each  parallel lane transmit bytes.
REQ-015 sbrx  in  1  sideband serial in; sbtx  out  1  sideband serial out.
REQ-016 enable_scr  out  1  scrambling enable to electrical layer.
REQ-017 cl0_s  out  1  link in CL0.

Function
REQ-018 Config registers: 0x00 CTRL RW (bit0 link_en, reset 0); 0x04 STATUS RO ({28'b0, state[1:0], sb_done, cl0_s}); 0x08 TXCNT RO; 0x0C RXCNT RO; others read 0, writes ignored.
REQ-019 c_write writes CTRL in the same edge; c_read loads c_data_out on the next edge; c_data_out holds otherwise; c_read and c_write together: write first, read returns new value.
REQ-020 TXCNT/RXCNT 32-bit, count words sent/received in CL0, wrap 0xFFFFFFFF->0, clear when leaving CL0.
REQ-021 States: DISABLED(0), SB_SYNC(1), LANE_TRAIN(2), CL0(3).
REQ-022 DISABLED -> SB_SYNC when link_en=1 and lane_disable=0.
REQ-023 Any state -> DISABLED on next edge when lane_disable=1 or link_en=0; takes priority over all transitions; sideband TX/RX aborted, counters cleared.
REQ-024 Sideband frame: idle 1, start 0, 8 data bits LSB first, stop 1; each bit SB_DIV cycles; sbtx=1 outside frames.
REQ-025 SB_SYNC: transmit byte 0x5A repeatedly (one idle bit-time between frames) until a valid frame 0x5A is received on sbrx; then sb_done=1 and -> LANE_TRAIN after current TX frame completes.
REQ-026 Sideband RX: detect falling edge, sample at mid-bit (SB_DIV/2 then every SB_DIV); stop bit 0 discards frame; bytes other than 0x5A ignored.
REQ-027 LANE_TRAIN: lane_0_tx_o=lane_1_tx_o=0xA5 every cycle; count cycles with enable_deser=1 and both rx==0xA5; mismatch with enable_deser=1 resets count; cycles with enable_deser=0 hold count; count==TRAIN_CNT -> CL0.
REQ-028 CL0: cl0_s=1; lane_0_tx_o=transport_layer_data_in[7:0], lane_1_tx_o=[15:8], registered (1-cycle latency); TXCNT increments each cycle.
REQ-029 CL0 receive: when enable_deser=1, transport_layer_data_out={lane_1_rx_i,lane_0_rx_i} and transport_data_flag=1 on next edge, RXCNT increments; flag 0 otherwise, data held.
REQ-030 enable_scr=1 in LANE_TRAIN and CL0, else 0.
REQ-031 Lane TX outputs 0x00 in DISABLED and SB_SYNC.

Reset
REQ-032 rst=1 asynchronously: state DISABLED, CTRL=0, counters 0, c_data_out=0, transport_layer_data_out=0, transport_data_flag=0, lane TX=0x00, sbtx=1, enable_scr=0, cl0_s=0, sb_done=0.

Verification
REQ-033 Reset then read 0x00 and 0x04 -> both 0x00000000; sbtx=1.
REQ-034 Write CTRL=1, lane_disable=0; loop sbtx->sbrx -> 0x5A frame seen on sbtx (bits 0,0,1,0,1,1,0,1,0,1), STATUS.state=2.
REQ-035 In LANE_TRAIN drive 0xA5 on both lanes with enable_deser=1 for 4 cycles -> cl0_s=1, enable_scr=1, STATUS=0x0000000D; a 0x00 on cycle 3 restarts count.
REQ-036 In CL0 send 7 words 0x1234.. -> lane_0_tx_o=0x34, lane_1_tx_o=0x12 one cycle later; rx {0xBE,0xEF} with enable_deser -> transport_layer_data_out=0xBEEF, flag pulse, RXCNT increments.
REQ-037 lane_disable=1 in CL0 -> next edge state 0, cl0_s=0, lane TX=0x00, counters 0.
REQ-038 Assert rst mid sideband frame -> sbtx=1 immediately, all outputs at reset values.
